// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the single-cycle core and its responder, plus the
// console drain port. The core side is the master. The responder is the slave.
//
// Handshake (console drain): console_valid is high whenever the FIFO holds a
// byte, and console_data is that head byte. A byte transfers on a rising edge
// where console_valid && console_ready are both high. console_valid never waits
// for console_ready, and the sink may hold console_ready high or low freely.
interface data_mem_responder_if;
  logic [31:0] data_mem_addr;
  logic        data_mem_read;
  logic [3:0]  data_mem_write;
  logic [31:0] data_mem_data_w;
  logic [31:0] data_mem_data_r;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready;

  modport master (
    output data_mem_addr, data_mem_read, data_mem_write, data_mem_data_w,
    output console_ready,
    input  data_mem_data_r, console_data, console_valid
  );

  modport slave (
    input  data_mem_addr, data_mem_read, data_mem_write, data_mem_data_w,
    input  console_ready,
    output data_mem_data_r, console_data, console_valid
  );
endinterface

// File: rtl/data_mem_responder.sv
// Responder for the core's data-memory bus. It contains a word RAM with
// byte-lane strobes and an MMIO window. The window holds a console TX FIFO,
// a 64-bit cycle counter with a HI snapshot, and a sticky halt register.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   bus,
  output logic                  halt,
  output logic [31:0]           halt_code,
  output logic                  bus_err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam int         PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] FIFO_FULL = 4'(FIFO_DEPTH);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [3:0]    fifo_cnt;
  logic          overflow;
  logic [63:0]   cycle_cnt;
  logic [31:0]   cycle_hi;

  logic          is_ram, is_mmio, unmapped, access;
  logic [1:0]    mmio_sel;
  logic [AW-1:0] ram_idx;
  logic          fifo_empty, fifo_full, pop, push_req, push_ok, halt_wr;
  logic [31:0]   status;
  logic          addr_unused;

  // Address decode. The byte offset within a word is not used.
  assign is_ram      = (bus.data_mem_addr[31:AW+2] == '0);
  assign is_mmio     = (bus.data_mem_addr[31:4] == MMIO_BASE[31:4]);
  assign unmapped    = !is_ram && !is_mmio;
  assign access      = bus.data_mem_read || (|bus.data_mem_write);
  assign mmio_sel    = bus.data_mem_addr[3:2];
  assign ram_idx     = bus.data_mem_addr[AW+1:2];
  assign addr_unused = ^bus.data_mem_addr[1:0];

  assign fifo_empty = (fifo_cnt == 4'd0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign pop        = !fifo_empty && bus.console_ready;
  assign push_req   = is_mmio && (mmio_sel == 2'd0) && bus.data_mem_write[0];
  // When the FIFO is full, a same-cycle pop frees the slot that the push takes.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign halt_wr    = is_mmio && (mmio_sel == 2'd3) && (|bus.data_mem_write);

  assign status = {25'd0, overflow, fifo_cnt, fifo_empty, fifo_full};

  assign bus.console_valid = !fifo_empty;
  assign bus.console_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  // Combinational load data. It reflects state before this edge's writes.
  always_comb begin
    bus.data_mem_data_r = '0;
    if (bus.data_mem_read) begin
      if (is_ram) begin
        bus.data_mem_data_r = ram[ram_idx];
      end else if (is_mmio) begin
        case (mmio_sel)
          2'd0:    bus.data_mem_data_r = status;
          2'd1:    bus.data_mem_data_r = cycle_cnt[31:0];
          2'd2:    bus.data_mem_data_r = cycle_hi;
          default: bus.data_mem_data_r = {31'd0, halt};
        endcase
      end
    end
  end

  // RAM byte-lane writes. These are blocked by reset and while halted.
  always_ff @(posedge clk) begin
    if (!rst && is_ram && !halt) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_mem_write[i]) ram[ram_idx][8*i +: 8] <= bus.data_mem_data_w[8*i +: 8];
      end
    end
  end

  // FIFO storage. Only accepted pushes write a slot.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) fifo_mem[wr_ptr] <= bus.data_mem_data_w[7:0];
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 4'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 4'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // Cycle counter, HI snapshot, halt capture and the sticky bus error.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      cycle_hi  <= '0;
      halt      <= 1'b0;
      halt_code <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (!halt) cycle_cnt <= cycle_cnt + 64'd1;
      if (bus.data_mem_read && is_mmio && (mmio_sel == 2'd1)) cycle_hi <= cycle_cnt[63:32];
      if (halt_wr) begin
        halt <= 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (bus.data_mem_write[i]) halt_code[8*i +: 8] <= bus.data_mem_data_w[8*i +: 8];
        end
      end
      if (access && unmapped) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. A behavioural model tracks RAM
// words, the console byte queue, the counter and the flags. Loads push their
// expected data when they are issued. A negedge monitor pops and compares them.
module tb_data_mem_responder;
  localparam int          DEPTH_WORDS = 16384;
  localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;
  localparam int          FIFO_DEPTH  = 4;
  localparam logic [31:0] A_CON  = MMIO_BASE;
  localparam logic [31:0] A_LO   = MMIO_BASE + 32'h4;
  localparam logic [31:0] A_HI   = MMIO_BASE + 32'h8;
  localparam logic [31:0] A_HALT = MMIO_BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic [31:0] halt_code;
  logic        bus_err;

  data_mem_responder_if bus();

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS), .MMIO_BASE(MMIO_BASE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .halt(halt), .halt_code(halt_code), .bus_err(bus_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] mram [int unsigned];
  logic [7:0]  mfifo[$];
  logic        movf, mhalt, merr;
  logic [63:0] mcnt;
  logic [31:0] mhi, mhcode;
  logic [31:0] m_a, m_dw;
  logic [3:0]  m_wr;
  logic        m_rd, m_ram, m_mmio, m_pop;
  logic [31:0] m_off;

  // scoreboard
  logic [31:0] exp_q[$];
  int  chk_cnt = 0;
  int  err_cnt = 0;
  bit  mon_en  = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] strb);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mdl_read(logic [31:0] a);
    logic [31:0] s = '0;
    if (a < 32'(DEPTH_WORDS * 4)) return mram.exists(a >> 2) ? mram[a >> 2] : 32'h0;
    if ((a & 32'hFFFF_FFF0) == MMIO_BASE) begin
      case (a & 32'hC)
        32'h0: begin
          s[0]   = (mfifo.size() == FIFO_DEPTH);
          s[1]   = (mfifo.size() == 0);
          s[5:2] = 4'(mfifo.size());
          s[6]   = movf;
          return s;
        end
        32'h4:   return mcnt[31:0];
        32'h8:   return mhi;
        default: return {31'd0, mhalt};
      endcase
    end
    return 32'h0;
  endfunction

  // Behavioural model. It applies one clock edge from the inputs in effect
  // during the preceding cycle.
  always @(posedge clk) begin
    m_a = bus.data_mem_addr; m_dw = bus.data_mem_data_w;
    m_wr = bus.data_mem_write; m_rd = bus.data_mem_read;
    if (rst) begin
      mfifo.delete(); movf = 0; mcnt = 0; mhi = 0; mhalt = 0; mhcode = 0; merr = 0;
    end else begin
      m_ram  = (m_a < 32'(DEPTH_WORDS * 4));
      m_mmio = ((m_a & 32'hFFFF_FFF0) == MMIO_BASE);
      m_off  = m_a & 32'hC;
      m_pop  = (mfifo.size() > 0) && bus.console_ready;
      if (!m_ram && !m_mmio && (m_rd || m_wr != 0)) merr = 1;
      if (m_ram && !mhalt && m_wr != 0)
        mram[m_a >> 2] = merge(mram.exists(m_a >> 2) ? mram[m_a >> 2] : 32'h0, m_dw, m_wr);
      if (m_pop) void'(mfifo.pop_front());
      if (m_mmio && m_off == 0 && m_wr[0]) begin
        if (mfifo.size() < FIFO_DEPTH) mfifo.push_back(m_dw[7:0]);
        else movf = 1;
      end
      if (m_mmio && m_off == 32'h4 && m_rd) mhi = mcnt[63:32];
      if (!mhalt) mcnt = mcnt + 64'd1;
      if (m_mmio && m_off == 32'hC && m_wr != 0) begin
        mhalt = 1; mhcode = merge(mhcode, m_dw, m_wr);
      end
    end
  end

  // monitor: loads, console drain and flags, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.data_mem_read) begin
        if (exp_q.size() == 0) check("load_no_expectation", 32'd1, 32'd0);
        else check("load_data", bus.data_mem_data_r, exp_q.pop_front());
      end
      check("console_valid", {31'd0, bus.console_valid}, {31'd0, (mfifo.size() != 0)});
      if (mfifo.size() == 0) check("console_data_empty", {24'd0, bus.console_data}, 32'd0);
      else if (bus.console_ready) check("console_pop", {24'd0, bus.console_data}, {24'd0, mfifo[0]});
      check("halt", {31'd0, halt}, {31'd0, mhalt});
      check("halt_code", halt_code, mhcode);
      check("bus_err", {31'd0, bus_err}, {31'd0, merr});
    end
  end

  // driver tasks: each occupies exactly one bus cycle
  task automatic clear_bus();
    bus.data_mem_read = 0; bus.data_mem_write = 0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; clear_bus(); end
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] strb);
    @(posedge clk); #1;
    bus.data_mem_addr = a; bus.data_mem_data_w = d;
    bus.data_mem_write = strb; bus.data_mem_read = 0;
  endtask

  task automatic rd_exp(logic [31:0] a, logic [31:0] e);
    @(posedge clk); #1;
    exp_q.push_back(e);
    bus.data_mem_addr = a; bus.data_mem_read = 1; bus.data_mem_write = 0;
  endtask

  task automatic rd(logic [31:0] a);
    @(posedge clk); #1;
    exp_q.push_back(mdl_read(a));
    bus.data_mem_addr = a; bus.data_mem_read = 1; bus.data_mem_write = 0;
  endtask

  task automatic rw(logic [31:0] a, logic [31:0] d, logic [3:0] strb, logic [31:0] e);
    @(posedge clk); #1;
    exp_q.push_back(e);
    bus.data_mem_addr = a; bus.data_mem_data_w = d;
    bus.data_mem_read = 1; bus.data_mem_write = strb;
  endtask

  logic [31:0] lo_frozen;

  initial begin
    rst = 1; bus.data_mem_addr = 0; bus.data_mem_data_w = 0;
    clear_bus(); bus.console_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_console_valid", {31'd0, bus.console_valid}, 32'd0);
    check("reset_console_data", {24'd0, bus.console_data}, 32'd0);
    check("reset_halt", {31'd0, halt}, 32'd0);
    check("reset_halt_code", halt_code, 32'd0);
    check("reset_bus_err", {31'd0, bus_err}, 32'd0);
    mon_en = 1;

    // RAM byte lanes and read-before-write
    wr(32'h100, 32'hAABB_CCDD, 4'b1111);
    wr(32'h100, 32'h0000_0011, 4'b0001);
    wr(32'h100, 32'h2200_0000, 4'b1000);
    rd_exp(32'h100, 32'h22BB_CC11);
    rd_exp(32'h102, 32'h22BB_CC11);
    wr(32'h40, 32'h7, 4'b1111);
    rw(32'h40, 32'h5, 4'b1111, 32'h7);
    rd_exp(32'h40, 32'h5);

    // FIFO fill past full, then drain
    wr(A_CON, 32'h51, 4'b1110);               // lane 0 clear: no push
    for (int c = 8'h41; c <= 8'h45; c++) wr(A_CON, 32'(c), 4'b0001);
    rd_exp(A_CON, 32'h51);                     // full, count 4, overflow
    idle(1);
    @(negedge clk); check("fifo_head_A", {24'd0, bus.console_data}, 32'h41);
    @(posedge clk); #1; clear_bus(); bus.console_ready = 1;
    idle(3);
    idle(1);
    @(negedge clk); check("fifo_drained_valid", {31'd0, bus.console_valid}, 32'd0);
    rd_exp(A_CON, 32'h42);                     // empty, overflow sticky

    // full FIFO with same-cycle pop and push
    @(posedge clk); #1; clear_bus(); bus.console_ready = 0;
    for (int c = 8'h31; c <= 8'h34; c++) wr(A_CON, 32'(c), 4'b0001);
    wr(A_CON, 32'h5A, 4'b0001); bus.console_ready = 1;
    rd_exp(A_CON, 32'h51); bus.console_ready = 0;
    @(posedge clk); #1; clear_bus(); bus.console_ready = 1;
    idle(3);
    @(negedge clk); check("fifo_Z_last", {24'd0, bus.console_data}, 32'h5A);
    idle(1);
    @(negedge clk); check("fifo_Z_drained", {31'd0, bus.console_valid}, 32'd0);

    // counter snapshot across the LO->HI carry
    @(posedge clk); #1; clear_bus();
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
    mcnt = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.cycle_cnt;
    exp_q.push_back(32'hFFFF_FFFF);
    bus.data_mem_addr = A_LO; bus.data_mem_read = 1;
    idle(4);
    rd_exp(A_HI, 32'h0);
    rd(A_LO);
    rd_exp(A_HI, 32'h1);
    wr(A_LO, 32'h1234, 4'b1111);               // read-only: ignored, no bus_err
    wr(A_HI, 32'h1234, 4'b1111);

    // randomized mix against the model
    for (int i = 0; i < 16; i++) wr(32'h200 + 32'(4 * i), $urandom, 4'b1111);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0, 1: wr(32'h200 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)),
                 $urandom, 4'($urandom_range(0, 15)));
        2:    rd(32'h200 + 32'(4 * $urandom_range(0, 15)));
        3:    wr(A_CON, $urandom, 4'($urandom_range(0, 15)));
        4:    rd(A_CON);
        5:    rd($urandom_range(0, 1) ? A_LO : A_HI);
        default: rd(A_HALT);
      endcase
      bus.console_ready = 1'($urandom_range(0, 1));
    end

    // unmapped access
    idle(1); bus.console_ready = 1;
    rd_exp(32'h8000_0000, 32'h0);
    idle(1);
    @(negedge clk); check("bus_err_set", {31'd0, bus_err}, 32'd1);
    idle(6);

    // halt
    wr(32'h0, 32'h1234_5678, 4'b1111);
    wr(A_HALT, 32'h0000_00AB, 4'b1111);
    idle(1);
    @(negedge clk);
    check("halt_set", {31'd0, halt}, 32'd1);
    check("halt_code_AB", halt_code, 32'hAB);
    lo_frozen = mcnt[31:0];
    wr(32'h0, 32'hDEAD_BEEF, 4'b1111);
    rd_exp(32'h0, 32'h1234_5678);
    rd_exp(A_LO, lo_frozen);
    idle(3);
    rd_exp(A_LO, lo_frozen);
    rd_exp(A_HALT, 32'h1);
    bus.console_ready = 0;
    wr(A_CON, 32'h48, 4'b0001);
    idle(1);
    @(negedge clk); check("push_while_halted", {31'd0, bus.console_valid}, 32'd1);
    wr(A_CON, 32'h49, 4'b0001);
    wr(A_CON, 32'h4A, 4'b0001);
    rd_exp(A_CON, 32'h4C);                     // count 3, overflow sticky

    // reset with 3 queued bytes while halted
    @(posedge clk); #1; clear_bus(); rst = 1;
    bus.data_mem_addr = 32'h100; bus.data_mem_data_w = 32'h0; bus.data_mem_write = 4'b1111;
    @(posedge clk); #1; rst = 0; clear_bus();
    exp_q.push_back(32'h0);
    bus.data_mem_addr = A_LO; bus.data_mem_read = 1;
    @(negedge clk);
    check("rst_console_valid", {31'd0, bus.console_valid}, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    rd_exp(32'h100, 32'h22BB_CC11);
    rd_exp(32'h40, 32'h5);
    idle(2);
    @(negedge clk);
    check("expected_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory bus. It serves loads and stores issued by the single-cycle core.
- It contains a word-organised RAM with byte-lane write strobes and a small MMIO window.
- The MMIO window holds a console TX FIFO with a ready/valid drain port, a 64-bit cycle counter with an atomic high-word snapshot, and a halt register.
- It sits beside the core in the top level and replaces a bare RAM model.

Parameters:
- DEPTH_WORDS, 16384, RAM size in 32-bit words. Must be a power of two.
- MMIO_BASE, 32'hFFFF_0000, base byte address of the MMIO window.
- FIFO_DEPTH, 4, console FIFO entries. Must be a power of two and at most 8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_mem_addr  in  32  byte address from the core.
- data_mem_read  in  1  load strobe.
- data_mem_write  in  4  byte-lane write strobes; bit n covers data bits [8n+7:8n].
- data_mem_data_w  in  32  store data.
- data_mem_data_r  out  32  load data; combinational in the same cycle.
- console_data  out  8  FIFO head byte.
- console_valid  out  1  FIFO not empty.
- console_ready  in  1  sink accepts the head byte.
- halt  out  1  sticky halt flag.
- halt_code  out  32  value captured when halt is written.
- bus_err  out  1  sticky flag: access to an unmapped address.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Clears FIFO pointers and count, the overflow flag, the 64-bit counter, the HI shadow, halt, halt_code and bus_err.
  - RAM contents are not cleared.
  - Post-reset outputs: console_valid=0, console_data=0, halt=0, halt_code=0, bus_err=0.
  - rst overrides every same-cycle access.
- Address decode:
  - RAM: addr < DEPTH_WORDS*4. Index is addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] is ignored.
  - MMIO: addr[31:4] == MMIO_BASE[31:4], selected by addr[3:2].
  - Any other address is unmapped.
- Reads:
  - data_mem_data_r = selected word when data_mem_read=1; otherwise 0.
  - Read data reflects state before any same-cycle write (read-before-write).
  - Unmapped reads return 0.
- RAM writes: on the clock edge, each lane whose strobe is set is written; other lanes are unchanged. Writes are ignored while halt=1.
- MMIO map:
  - 0x0 CONSOLE.
    - Write: a push occurs when data_mem_write[0]=1, using data bits [7:0]; other lanes are ignored.
    - Read status: bit0 full, bit1 empty, bits[5:2] count, bit6 overflow (sticky); all other bits 0.
  - 0x4 CYCLE_LO (read-only). Returns counter[31:0]. A load from it (data_mem_read=1) also latches counter[63:32] into the HI shadow on the same edge.
  - 0x8 CYCLE_HI (read-only). Returns the HI shadow.
  - 0xC HALT.
    - Write with any strobe set: halt<=1, and halt_code is lane-merged from data_mem_data_w.
    - Read: returns {31'b0, halt}.
    - Halt is sticky until rst.
  - Writes to 0x4 and 0x8 are ignored. They do not set bus_err.
- Any read or write to an unmapped address sets bus_err on the edge; bus_err is sticky until rst.
- Cycle counter:
  - Increments by 1 every cycle while halt=0 and rst=0; wraps from 2^64-1 to 0.
  - Freezes from the cycle after halt is set.
  - The value returned by a CYCLE_LO read is the pre-increment value.
- FIFO:
  - Pop occurs when console_valid & console_ready; console_data and console_valid are driven from registered FIFO state.
  - A push into an empty FIFO makes console_valid rise on the next cycle.
  - Push when full with no same-cycle pop: the byte is dropped, overflow<=1, and count is unchanged.
  - Push and pop in the same cycle when full: both succeed; count stays at FIFO_DEPTH.
  - Push and pop in the same cycle otherwise: count unchanged and pointers both advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - console_data=0 when the FIFO is empty.
- Console pushes are still accepted while halt=1, so the final message can drain.

Test Plan:
- RAM byte lanes:
  - Write 0xAABBCCDD to 0x100 with strobe 4'b1111, then 0x00000011 with strobe 4'b0001.
  - Then write 0x2200_0000 to 0x100 with strobe 4'b1000.
  - A read of 0x100 returns 0x22BBCC11. A read of 0x102 returns the same word.
- Read-before-write: read and write 0x5 to 0x40 in the same cycle, where 0x40 holds 0x7. data_r shows 0x7 that cycle and 0x5 the next.
- FIFO:
  - With console_ready=0, push 'A' through 'E' (5 pushes, FIFO_DEPTH=4).
  - Status read returns full=1, count=4, overflow=1; console_data='A'.
  - Raise console_ready: 'A','B','C','D' drain on 4 consecutive cycles, then console_valid=0 and empty=1.
  - Full FIFO with a simultaneous pop and push of 'Z': count stays 4 and 'Z' drains last.
- Counter snapshot:
  - Preload the counter to 0x0000_0000_FFFF_FFFF through the bench backdoor.
  - A CYCLE_LO read returns 0xFFFFFFFF; a CYCLE_HI read 5 cycles later returns 0x0.
  - The next LO/HI pair returns HI=0x1.
- Halt:
  - Write 0x0000_00AB to 0xFFFF_000C: halt=1 and halt_code=0xAB.
  - A later RAM write to 0x0 has no effect.
  - Counter reads on two different cycles return equal values.
  - A console push is still accepted.
- Errors and reset:
  - A read of 0x8000_0000 returns 0 and sets bus_err=1.
  - Asserting rst for one cycle while the FIFO is holding 3 bytes and halt=1 gives console_valid=0, halt=0, bus_err=0 and counter=0 on the next cycle; RAM contents are preserved.
